// File: rtl/vga_scan_controller.sv
// Scan controller for the 640x480@60 VGA path: raster counters, registered sync/blank/coords,
// and a per-line fetch scheduler with deadline tracking. Optional macro: UNDERRUN_BLANK_EN.
module vga_scan_controller #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PREFETCH = 32
) (
    input  logic       clk_25MHz,
    input  logic       rst,
    input  logic       line_ack,
    input  logic       clr_underrun,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic       line_req,
    output logic [9:0] line_idx,
    output logic       underrun,
    output logic [7:0] underrun_cnt
);

    localparam int unsigned CW      = 10;
    localparam int unsigned UW      = 8;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_BEG     = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG     = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] H_TRIG     = CW'(H_TOTAL - PREFETCH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          h_wrap_c;

    logic          hsync_n_q, hsync_n_d;
    logic          vsync_n_q, vsync_n_d;
    logic          video_on_q, video_on_d;
    logic [CW-1:0] pixel_x_q, pixel_x_d;
    logic [CW-1:0] pixel_y_q, pixel_y_d;
    logic          frame_start_q, frame_start_d;
    logic          active_c;

    logic [1:0]    state_q, state_d;
    logic          line_req_q, line_req_d;
    logic [CW-1:0] line_idx_q, line_idx_d;
    logic          underrun_q, underrun_d;
    logic [UW-1:0] underrun_cnt_q, underrun_cnt_d;
    logic          trig_c;
    logic          miss_c;
    logic [CW-1:0] next_line_c;

`ifdef UNDERRUN_BLANK_EN
    logic          bad_q, bad_d;
`endif

    // Raster counters
    always_comb begin
        h_wrap_c = (h_q == H_LAST);
        h_d      = h_wrap_c ? '0 : h_q + CW'(1);
        v_d      = v_q;
        if (h_wrap_c) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
        end
    end

    // Sync, blank and coordinates, one cycle behind the counters
    always_comb begin
        active_c      = (h_q < H_ACT) && (v_q < V_ACT);
        hsync_n_d     = !((h_q >= HS_BEG) && (h_q < HS_END));
        vsync_n_d     = !((v_q >= VS_BEG) && (v_q < VS_END));
`ifdef UNDERRUN_BLANK_EN
        video_on_d    = active_c && !bad_q;
`else
        video_on_d    = active_c;
`endif
        pixel_x_d     = active_c ? h_q : '0;
        pixel_y_d     = active_c ? v_q : '0;
        frame_start_d = (h_q == '0) && (v_q == '0);
    end

    // Fetch scheduler: request line L during the line before it, deadline at that line's end
    always_comb begin
        state_d        = state_q;
        line_req_d     = line_req_q;
        line_idx_d     = line_idx_q;
        underrun_d     = 1'b0;
        underrun_cnt_d = underrun_cnt_q;
        miss_c         = 1'b0;

        trig_c      = (h_q == H_TRIG) && ((v_q == V_LAST) || (v_q < V_ACT_LAST));
        next_line_c = (v_q == V_LAST) ? '0 : v_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                if (trig_c) begin
                    state_d    = ST_REQ;
                    line_req_d = 1'b1;
                    line_idx_d = next_line_c;
                end
            end
            ST_REQ: begin
                if (line_ack) begin
                    state_d    = ST_READY;
                    line_req_d = 1'b0;
                end else if (h_wrap_c) begin
                    state_d    = ST_IDLE;
                    line_req_d = 1'b0;
                    underrun_d = 1'b1;
                    miss_c     = 1'b1;
                end
            end
            ST_READY: begin
                // Leave once the fetched line has started so the next trigger is seen
                if (h_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                line_req_d = 1'b0;
            end
        endcase

        if (clr_underrun) begin
            underrun_cnt_d = '0;
        end else if (miss_c && (underrun_cnt_q != '1)) begin
            underrun_cnt_d = underrun_cnt_q + UW'(1);
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            h_q            <= '0;
            v_q            <= '0;
            hsync_n_q      <= 1'b1;
            vsync_n_q      <= 1'b1;
            video_on_q     <= 1'b0;
            pixel_x_q      <= '0;
            pixel_y_q      <= '0;
            frame_start_q  <= 1'b0;
            state_q        <= ST_IDLE;
            line_req_q     <= 1'b0;
            line_idx_q     <= '0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            h_q            <= h_d;
            v_q            <= v_d;
            hsync_n_q      <= hsync_n_d;
            vsync_n_q      <= vsync_n_d;
            video_on_q     <= video_on_d;
            pixel_x_q      <= pixel_x_d;
            pixel_y_q      <= pixel_y_d;
            frame_start_q  <= frame_start_d;
            state_q        <= state_d;
            line_req_q     <= line_req_d;
            line_idx_q     <= line_idx_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

`ifdef UNDERRUN_BLANK_EN
    // Bad mark covers exactly the line whose fetch was missed
    always_comb begin
        bad_d = bad_q;
        if (miss_c) begin
            bad_d = 1'b1;
        end else if (h_wrap_c) begin
            bad_d = 1'b0;
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            bad_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
        end
    end
`endif

    assign hsync_n      = hsync_n_q;
    assign vsync_n      = vsync_n_q;
    assign video_on     = video_on_q;
    assign pixel_x      = pixel_x_q;
    assign pixel_y      = pixel_y_q;
    assign frame_start  = frame_start_q;
    assign line_req     = line_req_q;
    assign line_idx     = line_idx_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule
